// File: rtl/pwm_cfg_scheduler_if.sv
// rtl/pwm_cfg_scheduler_if.sv - config, period and applied-output bundle for pwm_cfg_scheduler
interface pwm_cfg_scheduler_if #(
    parameter int DW = 10
);
    logic          cfg_toggle;
    logic          cfg_en_pwm;
    logic          cfg_mode_manual;
    logic [DW-1:0] cfg_duty_high;
    logic [DW-1:0] cfg_duty_low;
    logic [DW-1:0] cfg_freq;
    logic          period_end;
    logic [DW-1:0] auto_duty;
    logic          act_en;
    logic [DW-1:0] act_freq;
    logic [DW-1:0] act_duty;
    logic          cfg_pending;
    logic          cfg_err;
    logic [1:0]    state;

    modport master (
        output cfg_toggle, cfg_en_pwm, cfg_mode_manual, cfg_duty_high, cfg_duty_low,
               cfg_freq, period_end, auto_duty,
        input  act_en, act_freq, act_duty, cfg_pending, cfg_err, state
    );

    modport slave (
        input  cfg_toggle, cfg_en_pwm, cfg_mode_manual, cfg_duty_high, cfg_duty_low,
               cfg_freq, period_end, auto_duty,
        output act_en, act_freq, act_duty, cfg_pending, cfg_err, state
    );
endinterface

// File: rtl/pwm_cfg_scheduler.sv
// rtl/pwm_cfg_scheduler.sv - CDC capture, validation and period-aligned soft-start/stop of PWM config
module pwm_cfg_scheduler #(
    parameter int DW           = 10,
    parameter int RAMP_STEP    = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DEFAULT_FREQ = 500
) (
    input  logic                clk,
    input  logic                rst,
    pwm_cfg_scheduler_if.slave  bus
);
    localparam logic [DW:0]   STEP_W   = (DW+1)'(RAMP_STEP);
    localparam logic [DW-1:0] STEP_N   = DW'(RAMP_STEP);
    localparam logic [DW-1:0] FREQ_RST = DW'(DEFAULT_FREQ);

    typedef enum logic [1:0] {IDLE = 2'b00, RAMP = 2'b01, RUN = 2'b10, STOP = 2'b11} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   capture;
    logic                   cfg_valid;

    logic          stg_en, stg_manual;
    logic [DW-1:0] stg_dh, stg_dl, stg_freq;
    logic          cur_en, cur_manual;
    logic [DW-1:0] cur_dh, cur_dl, cur_freq;
    logic          pending_q, err_q;

    logic          apply;
    logic          eff_en, eff_manual;
    logic [DW-1:0] eff_dh, eff_dl, eff_freq;
    logic [DW-1:0] target, duty_max, up_next, dn_next, hold_next;
    logic [DW:0]   up_sum;

    state_t        st;
    logic          en_q;
    logic [DW-1:0] duty_q;

    // Toggle edge marks a finished register write; config fields are quasi-static by then.
    always_comb begin
        capture   = sync_q[SYNC_STAGES-1] ^ sync_prev;
        cfg_valid = (bus.cfg_freq >= DW'(2)) &&
                    (bus.cfg_duty_low <= bus.cfg_duty_high) &&
                    (bus.cfg_duty_high < bus.cfg_freq);
        apply     = bus.period_end && pending_q;
    end

    // The FSM sees the config that is active after this edge, so an applied enable acts at once.
    always_comb begin
        eff_en     = apply ? stg_en     : cur_en;
        eff_manual = apply ? stg_manual : cur_manual;
        eff_dh     = apply ? stg_dh     : cur_dh;
        eff_dl     = apply ? stg_dl     : cur_dl;
        eff_freq   = apply ? stg_freq   : cur_freq;
        if (eff_manual)
            target = eff_dh;
        else if (bus.auto_duty < eff_dl)
            target = eff_dl;
        else if (bus.auto_duty > eff_dh)
            target = eff_dh;
        else
            target = bus.auto_duty;
        duty_max  = eff_freq - DW'(1);
        up_sum    = {1'b0, duty_q} + STEP_W;
        up_next   = (up_sum > {1'b0, target}) ? target : up_sum[DW-1:0];
        dn_next   = (duty_q >= STEP_N) ? (duty_q - STEP_N) : '0;
        if (dn_next > duty_max)
            dn_next = duty_max;
        hold_next = (duty_q > duty_max) ? duty_max : duty_q;
    end

    // Multi-flop synchronizer for the SCK-domain toggle plus one flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.cfg_toggle};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    // Staging and active config; a capture coinciding with apply stays pending for the next period.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stg_en     <= 1'b0;
            stg_manual <= 1'b0;
            stg_dh     <= '0;
            stg_dl     <= '0;
            stg_freq   <= '0;
            cur_en     <= 1'b0;
            cur_manual <= 1'b0;
            cur_dh     <= '0;
            cur_dl     <= '0;
            cur_freq   <= FREQ_RST;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (apply) begin
                cur_en     <= stg_en;
                cur_manual <= stg_manual;
                cur_dh     <= stg_dh;
                cur_dl     <= stg_dl;
                cur_freq   <= stg_freq;
                pending_q  <= 1'b0;
            end
            if (capture) begin
                if (cfg_valid) begin
                    stg_en     <= bus.cfg_en_pwm;
                    stg_manual <= bus.cfg_mode_manual;
                    stg_dh     <= bus.cfg_duty_high;
                    stg_dl     <= bus.cfg_duty_low;
                    stg_freq   <= bus.cfg_freq;
                    pending_q  <= 1'b1;
                    err_q      <= 1'b0;
                end else begin
                    err_q      <= 1'b1;
                end
            end
        end
    end

    // Soft-start/stop sequencer; duty only moves on period_end, enable follows state entry/exit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st     <= IDLE;
            en_q   <= 1'b0;
            duty_q <= '0;
        end else begin
            case (st)
                IDLE: begin
                    duty_q <= '0;
                    if (eff_en) begin
                        st   <= RAMP;
                        en_q <= 1'b1;
                    end
                end
                RAMP: begin
                    if (!eff_en) begin
                        st <= STOP;
                        if (bus.period_end) duty_q <= hold_next;
                    end else if (bus.period_end) begin
                        duty_q <= up_next;
                        if (up_next == target) st <= RUN;
                    end
                end
                RUN: begin
                    if (!eff_en) begin
                        st <= STOP;
                        if (bus.period_end) duty_q <= hold_next;
                    end else if (bus.period_end) begin
                        duty_q <= target;
                    end
                end
                STOP: begin
                    if (eff_en) begin
                        st <= RAMP;
                    end else if (bus.period_end) begin
                        duty_q <= dn_next;
                        if (dn_next == '0) begin
                            st   <= IDLE;
                            en_q <= 1'b0;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.act_en      = en_q;
    assign bus.act_freq    = cur_freq;
    assign bus.act_duty    = duty_q;
    assign bus.cfg_pending = pending_q;
    assign bus.cfg_err     = err_q;
    assign bus.state       = st;
endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// tb/tb_pwm_cfg_scheduler.sv - scoreboard bench for pwm_cfg_scheduler
module tb_pwm_cfg_scheduler;
    localparam int DW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pwm_cfg_scheduler_if #(.DW(DW)) bus ();

    pwm_cfg_scheduler #(.DW(DW), .RAMP_STEP(4), .SYNC_STAGES(2), .DEFAULT_FREQ(500)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {bit en; bit man; int dh; int dl; int freq;} cfg_t;
    typedef struct {bit en; int freq; int duty; bit pend; bit err; int st;} exp_t;

    exp_t exp_q[$];
    cfg_t cap_cfg_q[$];
    int   cap_at_q[$];

    cfg_t m_stg, m_act, nc;
    bit   m_pend, m_err, m_en;
    int   m_duty, m_st, cyc, since_wr;
    int   n_chk, n_fail;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // Reference: per-edge behaviour written from the rules (states 0 idle,1 ramp,2 run,3 stop)
    task automatic model_edge(bit r, bit pe, int ad);
        cfg_t eff;
        cfg_t c;
        int   tgt;
        exp_t e;
        cyc++;
        if (!r) begin
            m_stg  = '{en:0, man:0, dh:0, dl:0, freq:0};
            m_act  = '{en:0, man:0, dh:0, dl:0, freq:500};
            m_pend = 0; m_err = 0; m_en = 0; m_duty = 0; m_st = 0;
            cap_cfg_q.delete();
            cap_at_q.delete();
        end else begin
            eff = (pe && m_pend) ? m_stg : m_act;
            tgt = eff.man ? eff.dh : imin(imax(ad, eff.dl), eff.dh);
            case (m_st)
                0: begin
                    m_duty = 0;
                    if (eff.en) begin m_st = 1; m_en = 1; end
                end
                1, 2: begin
                    if (!eff.en) begin
                        m_st = 3;
                        if (pe) m_duty = imin(m_duty, eff.freq - 1);
                    end else if (pe) begin
                        m_duty = (m_st == 1) ? imin(m_duty + 4, tgt) : tgt;
                        if (m_duty == tgt) m_st = 2;
                    end
                end
                default: begin
                    if (eff.en) m_st = 1;
                    else if (pe) begin
                        m_duty = imin(imax(m_duty - 4, 0), eff.freq - 1);
                        if (m_duty == 0) begin m_st = 0; m_en = 0; end
                    end
                end
            endcase
            if (pe && m_pend) begin
                m_act  = m_stg;
                m_pend = 0;
            end
            if (cap_at_q.size() > 0 && cap_at_q[0] == cyc) begin
                c = cap_cfg_q.pop_front();
                void'(cap_at_q.pop_front());
                if (c.freq >= 2 && c.dl <= c.dh && c.dh < c.freq) begin
                    m_stg = c; m_pend = 1; m_err = 0;
                end else begin
                    m_err = 1;
                end
            end
        end
        e = '{en:m_en, freq:m_act.freq, duty:m_duty, pend:m_pend, err:m_err, st:m_st};
        exp_q.push_back(e);
    endtask

    task automatic chk(string nm, int got, int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, got, want);
        end
    endtask

    // Monitor: every edge produces an output word; compare it against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("act_en",      int'(bus.act_en),      int'(e.en));
            chk("act_freq",    int'(bus.act_freq),    e.freq);
            chk("act_duty",    int'(bus.act_duty),    e.duty);
            chk("cfg_pending", int'(bus.cfg_pending), int'(e.pend));
            chk("cfg_err",     int'(bus.cfg_err),     int'(e.err));
            chk("state",       int'(bus.state),       e.st);
        end
    end

    task automatic step(bit r, bit pe, int ad, bit wr, cfg_t c);
        @(negedge clk);
        rst            = r;
        bus.period_end = pe;
        bus.auto_duty  = ad[DW-1:0];
        if (!r) begin
            bus.cfg_toggle = 1'b0;
        end else if (wr) begin
            bus.cfg_en_pwm      = c.en;
            bus.cfg_mode_manual = c.man;
            bus.cfg_duty_high   = c.dh[DW-1:0];
            bus.cfg_duty_low    = c.dl[DW-1:0];
            bus.cfg_freq        = c.freq[DW-1:0];
            bus.cfg_toggle      = ~bus.cfg_toggle;
            cap_cfg_q.push_back(c);
            cap_at_q.push_back(cyc + 3);
            since_wr = 0;
        end
        since_wr++;
        @(posedge clk);
        model_edge(r, pe, ad);
    endtask

    task automatic idle(int n, int ad);
        repeat (n) step(1, 0, ad, 0, nc);
    endtask

    task automatic period(int n, int ad);
        repeat (n) begin
            idle(7, ad);
            step(1, 1, ad, 0, nc);
        end
    endtask

    task automatic wr(cfg_t c, int ad);
        step(1, 0, ad, 1, c);
    endtask

    initial begin
        cfg_t c2, cbad, c4, c5;
        n_chk = 0; n_fail = 0; cyc = 0; since_wr = 10;
        nc   = '{en:0, man:0, dh:0, dl:0, freq:0};
        c2   = '{en:1, man:1, dh:40, dl:10, freq:100};
        cbad = '{en:1, man:1, dh:120, dl:10, freq:100};
        bus.cfg_toggle = 0; bus.cfg_en_pwm = 0; bus.cfg_mode_manual = 0;
        bus.cfg_duty_high = '0; bus.cfg_duty_low = '0; bus.cfg_freq = '0;
        bus.period_end = 0; bus.auto_duty = '0;

        repeat (3) step(0, 0, 0, 0, nc);
        idle(2, 0);

        wr(c2, 0);
        idle(4, 0);
        period(13, 0);

        wr(cbad, 0);
        idle(5, 0);
        wr(c2, 0);
        idle(5, 0);
        period(1, 0);

        c4 = c2; c4.freq = 200;
        wr(c4, 0);
        idle(1, 0);
        step(1, 1, 0, 0, nc);
        period(2, 0);
        c4.freq = 150; wr(c4, 0); idle(4, 0);
        c4.freq = 120; wr(c4, 0); idle(4, 0);
        period(2, 0);

        c5 = '{en:1, man:0, dh:40, dl:10, freq:100};
        wr(c5, 5); idle(4, 5);
        period(3, 5);
        period(3, 60);
        c5.en = 0;
        wr(c5, 60); idle(4, 60);
        period(13, 60);

        wr(c2, 0); idle(4, 0);
        period(6, 0);
        step(0, 0, 0, 0, nc);
        idle(3, 0);

        for (int i = 0; i < 1500; i++) begin
            int   r;
            int   ad;
            cfg_t c;
            r  = $urandom_range(0, 199);
            ad = $urandom_range(0, 1023);
            if (r == 0) begin
                step(0, 0, ad, 0, nc);
            end else if (r < 24 && since_wr >= 4) begin
                c.en   = ($urandom_range(0, 3) != 0);
                c.man  = $urandom_range(0, 1);
                c.freq = $urandom_range(0, 220);
                c.dh   = $urandom_range(0, 200);
                c.dl   = $urandom_range(0, 120);
                step(1, ($urandom_range(0, 5) == 0), ad, 1, c);
            end else begin
                step(1, ($urandom_range(0, 5) == 0), ad, 0, nc);
            end
        end

        idle(3, 0);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
